// File: rtl/axis_chk_pkg.sv
// Shared types and helpers for the AXI-Stream output-versus-expected checker.
package axis_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    TOUT = 2'd3
  } state_t;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  // Widest tdata the keep expander handles; callers cast the result down to their W.
  localparam int MAX_W  = 1024;
  localparam int MAX_KB = MAX_W / 8;

  function automatic logic [MAX_W-1:0] keep_mask(input logic [MAX_KB-1:0] keep);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_KB; i++) begin
      m[i*8 +: 8] = {8{keep[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_chk_lane.sv
// One channel: byte-wise compare of an output/expected beat pair under tkeep,
// beat index and end-of-stream tracking; results registered one cycle after the accept.
module axis_chk_lane
  import axis_chk_pkg::*;
#(
  parameter int W     = 64,
  parameter int ERR_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             run,
  input  logic             gate,
  input  logic [W-1:0]     out_tdata,
  input  logic [W/8-1:0]   out_tkeep,
  input  logic             out_tlast,
  input  logic             out_tvalid,
  input  logic [W-1:0]     exp_tdata,
  input  logic [W/8-1:0]   exp_tkeep,
  input  logic             exp_tlast,
  input  logic             exp_tvalid,
  output logic             tready,
  output logic             ch_fin,
  output logic             res_err,
  output logic [ERR_W-1:0] res_idx,
  output logic [W-1:0]     res_out,
  output logic [W-1:0]     res_exp
);

  logic [ERR_W-1:0] beat_idx;
  logic [W-1:0]     out_mask;
  logic [W-1:0]     exp_mask;
  logic [W-1:0]     out_masked;
  logic [W-1:0]     exp_masked;
  logic             mism;

  // Both streams share one ready so they always move together.
  assign tready = run & ~ch_fin & gate & out_tvalid & exp_tvalid;

  always_comb begin
    out_mask   = W'(keep_mask(MAX_KB'(out_tkeep)));
    exp_mask   = W'(keep_mask(MAX_KB'(exp_tkeep)));
    out_masked = out_tdata & out_mask;
    exp_masked = exp_tdata & exp_mask;
    mism       = (|((out_tdata ^ exp_tdata) & exp_mask)) |
                 (out_tkeep != exp_tkeep) | (out_tlast != exp_tlast);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      beat_idx <= '0;
      ch_fin   <= 1'b0;
      res_err  <= 1'b0;
      res_idx  <= '0;
      res_out  <= '0;
      res_exp  <= '0;
    end else begin
      res_err <= tready & mism;
      if (tready) begin
        res_idx  <= beat_idx;
        res_out  <= out_masked;
        res_exp  <= exp_masked;
        beat_idx <= beat_idx + ERR_W'(1);
        // Either side ending closes the channel, so a length mismatch costs one error.
        if (out_tlast || exp_tlast) ch_fin <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_stream_checker.sv
// Multi-channel AXI-Stream self-checker: run FSM, LFSR back-pressure, watchdog,
// saturating error count and lowest-channel-wins first-mismatch capture.
module axis_stream_checker
  import axis_chk_pkg::*;
#(
  parameter int          N_CH        = 4,
  parameter int          W           = 64,
  parameter int          ERR_W       = 32,
  parameter int          TIMEOUT_CYC = 1000000,
  parameter int          READY_PROB  = 100,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [N_CH*W-1:0]                          out_tdata,
  input  logic [N_CH*W/8-1:0]                        out_tkeep,
  input  logic [N_CH-1:0]                            out_tlast,
  input  logic [N_CH-1:0]                            out_tvalid,
  output logic [N_CH-1:0]                            out_tready,
  input  logic [N_CH*W-1:0]                          exp_tdata,
  input  logic [N_CH*W/8-1:0]                        exp_tkeep,
  input  logic [N_CH-1:0]                            exp_tlast,
  input  logic [N_CH-1:0]                            exp_tvalid,
  output logic [N_CH-1:0]                            exp_tready,
  output logic                                       done,
  output logic                                       pass,
  output logic [ERR_W-1:0]                           err_count,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] first_err_ch,
  output logic [ERR_W-1:0]                           first_err_idx,
  output logic [W-1:0]                               first_err_out,
  output logic [W-1:0]                               first_err_exp,
  output logic                                       timeout
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int KB   = W / 8;

  state_t           state_q, state_d;
  logic [31:0]      lfsr_q;
  logic [WD_W-1:0]  wd_q;
  logic             first_seen_q;
  logic             clr, run, any_acc, wd_exp;
  logic [N_CH-1:0]  gate, lane_rdy, ch_fin, res_err;
  logic [ERR_W-1:0] res_idx [N_CH];
  logic [W-1:0]     res_out [N_CH];
  logic [W-1:0]     res_exp [N_CH];
  logic [7:0]       lbyte;
  logic [ERR_W:0]   err_sum;
  logic [ERR_W-1:0] err_next;
  logic             hit;
  logic [CH_W-1:0]  hit_ch;
  logic [ERR_W-1:0] hit_idx;
  logic [W-1:0]     hit_out, hit_exp;

  assign run     = (state_q == RUN);
  assign clr     = start & ~run;
  assign any_acc = |lane_rdy;
  assign wd_exp  = (TIMEOUT_CYC != 0) && !any_acc && (wd_q == WD_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, TOUT: if (start) state_d = RUN;
      RUN: begin
        if (&ch_fin)     state_d = DONE;
        else if (wd_exp) state_d = TOUT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Channels beyond four reuse LFSR bytes modulo four.
  always_comb begin
    lbyte = '0;
    for (int c = 0; c < N_CH; c++) begin
      lbyte   = lfsr_q[(c % 4)*8 +: 8];
      gate[c] = (32'(lbyte) % 32'd100) < 32'(READY_PROB);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)      lfsr_q <= LFSR_SEED;
    else if (run) lfsr_q <= {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'h0);
  end

  always_ff @(posedge clk) begin
    if (rst || clr)   wd_q <= '0;
    else if (run)     wd_q <= any_acc ? '0 : wd_q + WD_W'(1);
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    axis_chk_lane #(.W(W), .ERR_W(ERR_W)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .run        (run),
      .gate       (gate[c]),
      .out_tdata  (out_tdata[c*W +: W]),
      .out_tkeep  (out_tkeep[c*KB +: KB]),
      .out_tlast  (out_tlast[c]),
      .out_tvalid (out_tvalid[c]),
      .exp_tdata  (exp_tdata[c*W +: W]),
      .exp_tkeep  (exp_tkeep[c*KB +: KB]),
      .exp_tlast  (exp_tlast[c]),
      .exp_tvalid (exp_tvalid[c]),
      .tready     (lane_rdy[c]),
      .ch_fin     (ch_fin[c]),
      .res_err    (res_err[c]),
      .res_idx    (res_idx[c]),
      .res_out    (res_out[c]),
      .res_exp    (res_exp[c])
    );
  end

  assign out_tready = lane_rdy;
  assign exp_tready = lane_rdy;

  // Descending scan so the lowest mismatching channel is the one left selected.
  always_comb begin
    hit     = 1'b0;
    hit_ch  = '0;
    hit_idx = '0;
    hit_out = '0;
    hit_exp = '0;
    err_sum = {1'b0, err_count};
    for (int c = N_CH - 1; c >= 0; c--) begin
      err_sum = err_sum + (ERR_W+1)'(res_err[c]);
      if (res_err[c]) begin
        hit     = 1'b1;
        hit_ch  = CH_W'(c);
        hit_idx = res_idx[c];
        hit_out = res_out[c];
        hit_exp = res_exp[c];
      end
    end
    err_next = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_count     <= '0;
      first_seen_q  <= 1'b0;
      first_err_ch  <= '0;
      first_err_idx <= '0;
      first_err_out <= '0;
      first_err_exp <= '0;
      timeout       <= 1'b0;
    end else begin
      if (hit) err_count <= err_next;
      if (hit && !first_seen_q) begin
        first_seen_q  <= 1'b1;
        first_err_ch  <= hit_ch;
        first_err_idx <= hit_idx;
        first_err_out <= hit_out;
        first_err_exp <= hit_exp;
      end
      if (run && state_d == TOUT) timeout <= 1'b1;
    end
  end

  assign done = (state_q == DONE) || (state_q == TOUT);
  assign pass = done & ~timeout & (err_count == '0);

endmodule

// File: tb/tb_axis_stream_checker.sv
// Randomized self-checking bench for axis_stream_checker; expected results come from a
// beat-list reference model plus the handshake timing the bench observes on the ports.
module tb_axis_stream_checker;

  localparam int N_CH = 2;
  localparam int W    = 64;
  localparam int KB   = W / 8;
  localparam int ERR_W = 32;
  localparam int TO   = 50;
  localparam int RP   = 30;
  localparam int MAXB = 128;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic clk = 1'b0;
  logic rst, start;
  logic [N_CH*W-1:0]  out_tdata, exp_tdata;
  logic [N_CH*KB-1:0] out_tkeep, exp_tkeep;
  logic [N_CH-1:0]    out_tlast, out_tvalid, out_tready;
  logic [N_CH-1:0]    exp_tlast, exp_tvalid, exp_tready;
  logic done, pass, timeout;
  logic [ERR_W-1:0] err_count, first_err_idx;
  logic [0:0]       first_err_ch;
  logic [W-1:0]     first_err_out, first_err_exp;

  always #5 clk = ~clk;

  axis_stream_checker #(
    .N_CH(N_CH), .W(W), .ERR_W(ERR_W), .TIMEOUT_CYC(TO), .READY_PROB(RP), .LFSR_SEED(32'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tlast(out_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready),
    .exp_tdata(exp_tdata), .exp_tkeep(exp_tkeep), .exp_tlast(exp_tlast),
    .exp_tvalid(exp_tvalid), .exp_tready(exp_tready),
    .done(done), .pass(pass), .err_count(err_count), .first_err_ch(first_err_ch),
    .first_err_idx(first_err_idx), .first_err_out(first_err_out),
    .first_err_exp(first_err_exp), .timeout(timeout)
  );

  beat_t ob[N_CH][MAXB];
  beat_t eb[N_CH][MAXB];
  int    olen[N_CH];
  int    elen[N_CH];
  int    acc_cyc[N_CH][MAXB];
  int    n_acc[N_CH];
  int    last_acc, done_cyc, hs_viol;
  int    duty_samp = 0, duty_rdy = 0;
  int    checks = 0, failures = 0;

  function automatic logic [63:0] kmask(input logic [7:0] k);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = k[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  task automatic gen_pair(input int c, input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.d = {$urandom, $urandom};
      b.k = ($urandom_range(0, 3) == 0) ? (8'($urandom) | 8'h01) : 8'hFF;
      b.l = (i == last_at);
      ob[c][i] = b;
      eb[c][i] = b;
    end
    olen[c] = n;
    elen[c] = n;
  endtask

  task automatic idle_inputs();
    out_tdata = '0; out_tkeep = '0; out_tlast = '0; out_tvalid = '0;
    exp_tdata = '0; exp_tkeep = '0; exp_tlast = '0; exp_tvalid = '0;
  endtask

  // Pulses start, streams the beat lists and records when each beat was accepted.
  task automatic run_scenario(input int budget);
    int  op[N_CH];
    int  ep[N_CH];
    bit  fin[N_CH];
    for (int c = 0; c < N_CH; c++) begin
      op[c] = 0; ep[c] = 0; fin[c] = 1'b0; n_acc[c] = 0;
    end
    last_acc = -1; done_cyc = -1; hs_viol = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      start = (k == 0);
      for (int c = 0; c < N_CH; c++) begin
        beat_t o, e;
        o = (op[c] < olen[c]) ? ob[c][op[c]] : '0;
        e = (ep[c] < elen[c]) ? eb[c][ep[c]] : '0;
        out_tdata[c*W +: W] = o.d; out_tkeep[c*KB +: KB] = o.k; out_tlast[c] = o.l;
        exp_tdata[c*W +: W] = e.d; exp_tkeep[c*KB +: KB] = e.k; exp_tlast[c] = e.l;
        out_tvalid[c] = (op[c] < olen[c]);
        exp_tvalid[c] = (ep[c] < elen[c]);
      end
      #1;
      if (k > 0 && done === 1'b1) begin
        done_cyc = k;
        break;
      end
      for (int c = 0; c < N_CH; c++) begin
        if (out_tready[c] !== exp_tready[c]) hs_viol++;
        if (out_tready[c] && (fin[c] || !out_tvalid[c] || !exp_tvalid[c])) hs_viol++;
        if (k > 0 && !fin[c] && out_tvalid[c] && exp_tvalid[c]) begin
          duty_samp++;
          if (out_tready[c]) duty_rdy++;
        end
        if (out_tready[c] && out_tvalid[c] && exp_tvalid[c]) begin
          acc_cyc[c][n_acc[c]] = k;
          if (ob[c][op[c]].l || eb[c][ep[c]].l) fin[c] = 1'b1;
          n_acc[c]++; op[c]++; ep[c]++;
          last_acc = k;
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    idle_inputs();
    #1;
  endtask

  // Reference: walk the beat lists by the comparison rules; first error is the earliest
  // observed accept, ties going to the lower channel.
  task automatic check_results(input string name);
    int exp_n[N_CH];
    int errs, fc, fi, fk;
    logic [63:0] fo, fe;
    errs = 0; fc = 0; fi = 0; fk = 32'h7FFF_FFFF; fo = '0; fe = '0;
    for (int c = 0; c < N_CH; c++) begin
      exp_n[c] = 0;
      for (int i = 0; i < olen[c] && i < elen[c]; i++) begin
        beat_t o, e;
        o = ob[c][i]; e = eb[c][i];
        exp_n[c]++;
        if ((((o.d ^ e.d) & kmask(e.k)) != 64'd0) || o.k != e.k || o.l != e.l) begin
          errs++;
          if (i < n_acc[c] && acc_cyc[c][i] < fk) begin
            fk = acc_cyc[c][i]; fc = c; fi = i;
            fo = o.d & kmask(o.k); fe = e.d & kmask(e.k);
          end
        end
        if (o.l || e.l) break;
      end
      checks++;
      if (n_acc[c] !== exp_n[c]) begin
        failures++;
        $display("FAIL %s beats_ch%0d: got %0d expected %0d", name, c, n_acc[c], exp_n[c]);
      end
    end
    checks++;
    if (done_cyc < 0 || done_cyc !== last_acc + 2) begin
      failures++;
      $display("FAIL %s done_latency: done at %0d expected %0d", name, done_cyc, last_acc + 2);
    end
    checks++;
    if (err_count !== ERR_W'(errs)) begin
      failures++;
      $display("FAIL %s err_count: got %0d expected %0d", name, err_count, errs);
    end
    checks++;
    if (pass !== (errs == 0) || timeout !== 1'b0) begin
      failures++;
      $display("FAIL %s pass/timeout: got %b/%b expected %b/0", name, pass, timeout, errs == 0);
    end
    checks++;
    if (hs_viol !== 0) begin
      failures++;
      $display("FAIL %s handshake: got %0d violations expected 0", name, hs_viol);
    end
    if (errs > 0) begin
      checks++;
      if (first_err_ch !== 1'(fc) || first_err_idx !== ERR_W'(fi) ||
          first_err_out !== fo || first_err_exp !== fe) begin
        failures++;
        $display("FAIL %s first_err: got ch=%0d idx=%0d out=%h exp=%h expected ch=%0d idx=%0d out=%h exp=%h",
                 name, first_err_ch, first_err_idx, first_err_out, first_err_exp, fc, fi, fo, fe);
      end
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (out_tready !== '0 || exp_tready !== '0 || done !== 1'b0 || pass !== 1'b0 ||
        err_count !== '0 || timeout !== 1'b0 || first_err_ch !== '0 || first_err_idx !== '0 ||
        first_err_out !== '0 || first_err_exp !== '0) begin
      failures++;
      $display("FAIL %s: got rdy=%b/%b done=%b pass=%b err=%0d tout=%b fch=%0d fidx=%0d expected all zero",
               name, out_tready, exp_tready, done, pass, err_count, timeout, first_err_ch, first_err_idx);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; idle_inputs();
    out_tvalid = '1; exp_tvalid = '1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0; idle_inputs();
  endtask

  task automatic test_pass();
    for (int c = 0; c < N_CH; c++) gen_pair(c, 8, 7);
    run_scenario(400);
    check_results("pass8");
  endtask

  task automatic test_byte_err();
    for (int c = 0; c < N_CH; c++) gen_pair(c, 8, 7);
    ob[1][3].k = 8'hFF; eb[1][3].k = 8'hFF;
    ob[1][3].d[7:0] = 8'h11; eb[1][3].d = ob[1][3].d; eb[1][3].d[7:0] = 8'h22;
    run_scenario(400);
    check_results("byte_err");
  endtask

  task automatic test_keep_masked();
    for (int c = 0; c < N_CH; c++) gen_pair(c, 8, 7);
    ob[1][3].k = 8'hFE; eb[1][3].k = 8'hFE;
    ob[1][3].d[7:0] = 8'h11; eb[1][3].d = ob[1][3].d; eb[1][3].d[7:0] = 8'h22;
    run_scenario(400);
    check_results("keep_masked");
  endtask

  task automatic test_len_mismatch();
    for (int c = 0; c < N_CH; c++) gen_pair(c, 8, 7);
    ob[0][5].l = 1'b1;
    olen[0] = 6;
    run_scenario(400);
    check_results("len_mismatch");
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      for (int c = 0; c < N_CH; c++) begin
        gen_pair(c, 64, 63);
        for (int i = 0; i < 64; i++) begin
          if ($urandom_range(0, 15) == 0) begin
            if ($urandom_range(0, 2) != 0) ob[c][i].d[8*$urandom_range(0, 7) +: 8] ^= 8'h5A;
            else ob[c][i].k ^= 8'(1 << $urandom_range(0, 7));
          end
        end
      end
      if (it == 2) ob[$urandom_range(0, N_CH-1)][40].l = 1'b1;
      run_scenario(2000);
      check_results($sformatf("random%0d", it));
    end
  endtask

  task automatic test_timeout();
    for (int c = 0; c < N_CH; c++) begin
      gen_pair(c, 8, -1);
      elen[c] = 2;
    end
    run_scenario(600);
    checks++;
    if (last_acc < 0 || done_cyc !== last_acc + TO + 1) begin
      failures++;
      $display("FAIL timeout_latency: done at %0d expected %0d", done_cyc, last_acc + TO + 1);
    end
    checks++;
    if (timeout !== 1'b1 || done !== 1'b1 || pass !== 1'b0 || n_acc[0] !== 2 || n_acc[1] !== 2) begin
      failures++;
      $display("FAIL timeout_status: got tout=%b done=%b pass=%b acc=%0d/%0d expected 1 1 0 2/2",
               timeout, done, pass, n_acc[0], n_acc[1]);
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1;
    checks++;
    if (timeout !== 1'b0 || done !== 1'b0 || err_count !== '0) begin
      failures++;
      $display("FAIL rearm: got tout=%b done=%b err=%0d expected 0 0 0", timeout, done, err_count);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_rst_mid_run();
    for (int c = 0; c < N_CH; c++) gen_pair(c, 64, 63);
    ob[1][0].d ^= 64'hFF00;
    ob[1][0].k = 8'hFF; eb[1][0].k = 8'hFF;
    run_scenario(40);
    for (int c = 0; c < N_CH; c++) begin
      out_tvalid[c] = 1'b1; exp_tvalid[c] = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("rst_mid_run");
    @(negedge clk);
    rst = 1'b0; idle_inputs();
  endtask

  task automatic test_duty();
    checks++;
    if (duty_samp == 0 || duty_rdy * 100 < duty_samp * 20 || duty_rdy * 100 > duty_samp * 40) begin
      failures++;
      $display("FAIL ready_duty: got %0d of %0d cycles expected 20%%..40%%", duty_rdy, duty_samp);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_byte_err();
    test_keep_masked();
    test_len_mismatch();
    test_random();
    test_timeout();
    test_rst_mid_run();
    test_duty();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_stream_checker.md
Name: axis_stream_checker

Overview:
- Synthesisable, parametrised multi-channel self-checker for output-versus-expected comparison of accelerator streams.
- Per channel, consumes an output AXI-Stream and an expected AXI-Stream in lockstep and compares data byte-wise under tkeep.
- Reports pass/fail, error count, first-mismatch details and a watchdog timeout.
- Sits after the S2MM path in simulation and on-FPGA harnesses, replacing file-based comparison.

Parameters:
- N_CH, 4, number of independent channel pairs.
- W, 64, tdata width per channel in bits; multiple of 8.
- ERR_W, 32, width of the error counter and beat index.
- TIMEOUT_CYC, 1000000, cycles without any accepted beat before timeout; 0 disables the watchdog.
- READY_PROB, 100, percent probability that tready is asserted per cycle (LFSR-driven back-pressure); 100 means always ready.
- LFSR_SEED, 32'hACE1, non-zero seed of the shared 32-bit Galois LFSR.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle pulse; arms the checker and clears all status.
- out_tdata  in  N_CH*W  output data per channel.
- out_tkeep  in  N_CH*W/8  byte-valid mask per channel.
- out_tlast  in  N_CH  last beat per channel.
- out_tvalid  in  N_CH  valid per channel.
- out_tready  out  N_CH  ready per channel.
- exp_tdata, exp_tkeep, exp_tlast, exp_tvalid  in  same widths as out_*  expected stream.
- exp_tready  out  N_CH  ready per channel.
- done  out  1  level; all channels finished or timeout.
- pass  out  1  level; valid when done; 1 iff err_count==0 and no timeout.
- err_count  out  ERR_W  total mismatching beats (saturating).
- first_err_ch  out  $clog2(N_CH) (minimum 1)  channel of the first mismatch.
- first_err_idx  out  ERR_W  beat index within that channel.
- first_err_out, first_err_exp  out  W  captured data at the first mismatch, masked by the respective tkeep.
- timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset values:
  - all readys 0, done 0, pass 0, err_count 0, timeout 0.
  - first_err_* 0, FSM in IDLE, LFSR loaded with LFSR_SEED.
- FSM states:
  - IDLE -> RUN on start; clears counters, first_err_*, and per-channel ch_fin and beat_idx.
  - RUN -> DONE when all ch_fin are set.
  - RUN -> TOUT when the watchdog expires.
  - DONE and TOUT -> RUN on start (re-arm). A start pulse while in RUN is ignored.
- Readys:
  - In RUN only, and only for channels with ch_fin==0: out_tready[c] = exp_tready[c] = gate[c] & out_tvalid[c] & exp_tvalid[c].
  - gate[c] = (lfsr byte c mod 100) < READY_PROB.
  - Readys depend combinationally on the valids. Both streams therefore transfer in the same cycle, and each stream's valid stays independent of its ready.
- Beat accepted on channel c, results registered 1 cycle later:
  - mismatch if (out_tdata ^ exp_tdata) masked by exp_tkeep is non-zero, or out_tkeep != exp_tkeep, or out_tlast != exp_tlast.
  - A mismatch increments err_count (saturating at all-ones).
  - If it is the first mismatch since start, capture ch, beat_idx, and the masked data.
  - Simultaneous first mismatches on several channels: the lowest channel index wins.
  - beat_idx[c] increments on every beat and wraps at 2^ERR_W.
  - On exp_tlast or out_tlast, set ch_fin[c]. This covers length mismatch, which also counts as one error.
- Watchdog:
  - Counter cleared on any accepted beat and on entry to RUN.
  - Increments otherwise in RUN; reaching TIMEOUT_CYC sets timeout and enters TOUT.
- done=1 in DONE/TOUT. pass = done & ~timeout & (err_count==0). All status holds until the next start or rst.
- rst mid-run: returns to reset values immediately; any in-flight beats are not acknowledged.
- LFSR advances every cycle in RUN and uses a byte per channel (channels beyond 4 reuse bytes modulo 4).

Decomposition:
- Package axis_chk_pkg: state enum (IDLE, RUN, DONE, TOUT), function keep_mask(W) expanding tkeep into a bit mask, LFSR polynomial constant 32'h80200003.
- Sub-module axis_chk_lane: per-channel compare, beat_idx and ch_fin. Instantiated N_CH times via generate. The top-level module holds the FSM, LFSR, watchdog, error counter and first-error priority select.

Test Plan:
- N_CH=2, W=64, READY_PROB=100; 8 identical beats per channel, tlast on beat 7 -> done after the last beat plus 1 cycle, pass=1, err_count=0.
- Channel 1, beat 3: out_tdata differs only in byte 0 (0x11 vs 0x22), tkeep=0xFF -> err_count=1, first_err_ch=1, first_err_idx=3, pass=0.
- Same byte difference but exp_tkeep=0xFE on that beat (out_tkeep also 0xFE) -> no error; pass=1.
- Channel 0: output tlast on beat 5, expected tlast on beat 7 -> err_count=1, ch_fin[0] set after beat 5, first_err_idx=5.
- TIMEOUT_CYC=50; expected stream stalls after 2 beats -> timeout=1 exactly 50 cycles after the last accept, done=1, pass=0; a following start re-arms with timeout=0.
- READY_PROB=30; 64 beats per channel -> ready duty cycle between 20% and 40%, results identical to READY_PROB=100; rst asserted mid-run -> all outputs return to reset values on the next clk edge.
